// File: rtl/mic_get_samples_pkg.sv
// mic_get_samples_pkg
// Shared types and sizing for the microphone sample grabber:
//   spi_state_t   - SPI conversion sequencer states
//   SAMPLE_BITS   - default bits per conversion (equals the default stream width)
//   BIT_CNT_W     - width of a counter that must reach SAMPLE_BITS inclusive
//   bit_cnt_width - same sizing rule for a non-default sample width
package mic_get_samples_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } spi_state_t;

  localparam int SAMPLE_BITS = 16;

  function automatic int bit_cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

  localparam int BIT_CNT_W = bit_cnt_width(SAMPLE_BITS);

endpackage

// File: rtl/mic_sample_fifo.sv
// mic_sample_fifo
// Synchronous FIFO with a registered AXI4-Stream style output stage. The
// output register holds the head word, so total storage is DEPTH + 1 words.
// A write while the RAM is full is silently dropped.
// Ports:
//   clock   - sole clock
//   resetn  - synchronous active-low reset (empties FIFO, clears output)
//   wr_en   - write strobe for wr_data
//   wr_data - word to store
//   tvalid  - head word valid
//   tdata   - head word
//   tready  - consumer accepts head word when tvalid is also high
module mic_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  input  logic              tready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              do_write;
  logic              do_read;

  assign full     = (count == (ADDR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_write = wr_en && !full;
  // Refill the output register when it is empty or its word is being taken.
  assign do_read  = !empty && (!tvalid || tready);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tvalid <= 1'b0;
      tdata  <= '0;
    end else begin
      if (do_write) begin
        ram[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end

      if (do_read) begin
        tdata  <= ram[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        tvalid <= 1'b1;
      end else if (tvalid && tready) begin
        // Last word taken; tdata keeps its value.
        tvalid <= 1'b0;
      end

      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mic_get_samples.sv
// mic_get_samples
// Periodic SPI master reading samples from a microphone ADC, buffering them
// and presenting them on an AXI4-Stream master port.
// Ports:
//   m00_axis_aclk    - sole clock
//   m00_axis_aresetn - synchronous active-low reset
//   m00_axis_tvalid  - output word valid
//   m00_axis_tdata   - sample, MSB is the first bit received
//   m00_axis_tstrb   - byte strobes, always all ones
//   m00_axis_tready  - consumer ready
//   spi_clock        - SPI clock, idles high
//   spi_chipselect   - active-low chip select
//   spi_data         - serial data from the ADC (changes on SCLK falling edges)
//
// SPI sequencer states:
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | CS high, SCLK high, waiting for the period counter wrap
//   ST_SETUP | CS low, SCLK high for CLK_TRIG cycles
//   ST_LOW   | SCLK low for CLK_TRIG cycles
//   ST_HIGH  | SCLK high for CLK_TRIG cycles; bit sampled on entry
//   ST_DONE  | CS low, SCLK high for CLK_TRIG cycles, then word stored
module mic_get_samples
  import mic_get_samples_pkg::*;
#(
  parameter int CLK_TRIG               = 2,
  parameter int GRAB_TRIG              = 128,
  parameter int RAM_ADDR_WIDTH         = 2,
  parameter int C_M00_AXIS_TDATA_WIDTH = SAMPLE_BITS
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_aresetn,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  input  logic                                m00_axis_tready,
  output logic                                spi_clock,
  output logic                                spi_chipselect,
  input  logic                                spi_data
);

  localparam int W     = C_M00_AXIS_TDATA_WIDTH;
  // The package width already covers the default sample size.
  localparam int BIT_W = (W == SAMPLE_BITS) ? BIT_CNT_W : bit_cnt_width(W);
  localparam int PER_W = $clog2(GRAB_TRIG);
  localparam int TMR_W = $clog2(CLK_TRIG + 1);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLK_TRIG - 1);

  spi_state_t       state;
  logic [PER_W-1:0] per_cnt;
  logic [TMR_W-1:0] timer;
  logic [BIT_W-1:0] bit_cnt;
  logic [W-1:0]     shift_reg;
  logic             per_wrap;
  logic             tmr_done;
  logic             last_bit;
  logic             fifo_wr;

  assign per_wrap = (per_cnt == PER_W'(GRAB_TRIG - 1));
  assign tmr_done = (timer == '0);
  assign last_bit = (bit_cnt == BIT_W'(W));
  // Store on the same edge that raises CS.
  assign fifo_wr  = (state == ST_DONE) && tmr_done;

  assign m00_axis_tstrb = '1;

  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      per_cnt        <= '0;
      state          <= ST_IDLE;
      timer          <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      spi_clock      <= 1'b1;
      spi_chipselect <= 1'b1;
    end else begin
      per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;

      // Phase timer counts down; each state reloads it on its terminal count.
      if (!tmr_done) begin
        timer <= timer - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // A wrap while a conversion is still running is simply skipped.
          if (per_wrap) begin
            state          <= ST_SETUP;
            spi_chipselect <= 1'b0;
            timer          <= TMR_LOAD;
            bit_cnt        <= '0;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state     <= ST_LOW;
            spi_clock <= 1'b0;
            timer     <= TMR_LOAD;
          end
        end
        ST_LOW: begin
          if (tmr_done) begin
            state     <= ST_HIGH;
            spi_clock <= 1'b1;
            timer     <= TMR_LOAD;
            shift_reg <= {shift_reg[W-2:0], spi_data};
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (tmr_done) begin
            timer <= TMR_LOAD;
            if (last_bit) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_LOW;
              spi_clock <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (tmr_done) begin
            state          <= ST_IDLE;
            spi_chipselect <= 1'b1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          spi_clock      <= 1'b1;
          spi_chipselect <= 1'b1;
        end
      endcase
    end
  end

  mic_sample_fifo #(
    .DATA_W(W),
    .ADDR_W(RAM_ADDR_WIDTH)
  ) u_fifo (
    .clock  (m00_axis_aclk),
    .resetn (m00_axis_aresetn),
    .wr_en  (fifo_wr),
    .wr_data(shift_reg),
    .tvalid (m00_axis_tvalid),
    .tdata  (m00_axis_tdata),
    .tready (m00_axis_tready)
  );

endmodule

// File: tb/tb_mic_get_samples.sv
// tb_mic_get_samples
// Scoreboard bench: an ADC model serialises words onto spi_data and, when a
// conversion completes, pushes the word into the expected queue (a 5-word
// buffer model that drops when full). A monitor pops and compares on every
// stream handshake.
module tb_mic_get_samples;

  localparam int W   = 16;
  localparam int CAP = 5;

  logic         clk;
  logic         aresetn;
  logic         tvalid;
  logic [W-1:0] tdata;
  logic [1:0]   tstrb;
  logic         tready;
  logic         spi_clock;
  logic         spi_chipselect;
  logic         spi_data;

  int total = 0;
  int bad   = 0;
  int n_pops   = 0;
  int fall_cnt = 0;
  int rise_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] adc_q[$];

  mic_get_samples #(
    .CLK_TRIG(2),
    .GRAB_TRIG(128),
    .RAM_ADDR_WIDTH(2),
    .C_M00_AXIS_TDATA_WIDTH(W)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(aresetn),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tready (tready),
    .spi_clock       (spi_clock),
    .spi_chipselect  (spi_chipselect),
    .spi_data        (spi_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic wait_cs(input logic lvl, input int max, input string nm);
    int n;
    n = 0;
    while (spi_chipselect !== lvl && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, {31'd0, spi_chipselect}, {31'd0, lvl});
  endtask

  task automatic take_word(input string nm);
    int n;
    n = 0;
    while (tvalid !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (tvalid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: no tvalid within %0d cycles, got %0b want 1", nm, n, tvalid);
    end else begin
      tready = 1'b1;
      @(posedge clk); #1;
      tready = 1'b0;
    end
  endtask

  task automatic drain_all();
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) take_word("drain");
  endtask

  // ADC model: one word per CS-low window, MSB first on SCLK falling edges.
  initial begin
    logic [W-1:0] w;
    logic         aborted;
    forever begin
      @(negedge spi_chipselect);
      fall_cnt = 0;
      rise_cnt = 0;
      w = (adc_q.size() > 0) ? adc_q.pop_front() : W'($urandom);
      aborted = 1'b0;
      for (int k = 0; k < W; k++) begin
        @(negedge spi_clock or posedge spi_chipselect);
        if (spi_chipselect) begin
          aborted = 1'b1;
          break;
        end
        spi_data = w[W-1-k];
      end
      if (!aborted) @(posedge spi_chipselect);
      if (!aborted && aresetn === 1'b1 && exp_q.size() < CAP) exp_q.push_back(w);
    end
  end

  initial forever begin
    @(negedge spi_clock);
    if (spi_chipselect === 1'b0) fall_cnt++;
  end

  initial forever begin
    @(posedge spi_clock);
    if (spi_chipselect === 1'b0) rise_cnt++;
  end

  // Monitor: handshakes seen at the falling aclk edge complete at the next rising edge.
  initial begin
    logic         hold;
    logic [W-1:0] held;
    logic [W-1:0] e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (aresetn !== 1'b1) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("stall_tvalid", {31'd0, tvalid}, 32'd1);
          chk("stall_tdata", {16'd0, tdata}, {16'd0, held});
        end
        if (tvalid === 1'b1 && tready === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h want none", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", {16'd0, tdata}, {16'd0, e});
            chk("tstrb", {30'd0, tstrb}, 32'd3);
          end
          n_pops++;
        end
        hold = (tvalid === 1'b1) && (tready === 1'b0);
        held = tdata;
      end
    end
  end

  initial begin
    int n;
    int target;
    aresetn  = 1'b0;
    tready   = 1'b0;
    spi_data = 1'b0;

    repeat (10) begin
      @(posedge clk); #1;
      chk("rst_sclk", {31'd0, spi_clock}, 32'd1);
      chk("rst_cs", {31'd0, spi_chipselect}, 32'd1);
      chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
      chk("rst_tdata", {16'd0, tdata}, 32'd0);
    end
    @(negedge clk);
    aresetn = 1'b1;

    // First conversion: start latency and frame shape.
    n = 0;
    while (spi_chipselect === 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_cs_fall_cycle", n, 128);
    chk("sclk_at_cs_fall", {31'd0, spi_clock}, 32'd1);
    n = 0;
    while (spi_chipselect === 1'b0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cs_low_cycles", n, 68);
    chk("sclk_at_cs_rise", {31'd0, spi_clock}, 32'd1);
    chk("sclk_falls", fall_cnt, 16);
    chk("sclk_rises", rise_cnt, 16);
    drain_all();

    // Consecutive conversions, fixed then random words.
    for (int i = 2; i <= 11; i++) begin
      adc_q.push_back(W'(i));
      take_word("seq_word");
    end
    for (int i = 0; i < 10; i++) begin
      adc_q.push_back(W'($urandom));
      take_word("rand_word");
    end

    // Backpressure: six words into a five-word buffer.
    wait_cs(1'b0, 300, "bp_sync_fall");
    wait_cs(1'b1, 300, "bp_sync_rise");
    drain_all();
    for (int i = 1; i <= 6; i++) adc_q.push_back(W'(16'h1111 * i));
    repeat (6) begin
      wait_cs(1'b0, 300, "bp_fall");
      wait_cs(1'b1, 300, "bp_rise");
    end
    chk("bp_tvalid_full", {31'd0, tvalid}, 32'd1);
    chk("bp_head", {16'd0, tdata}, 32'h1111);
    target = n_pops + 5;
    tready = 1'b1;
    n = 0;
    while (n_pops < target && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_pops", n_pops, target);
    chk("bp_tvalid_empty", {31'd0, tvalid}, 32'd0);
    chk("bp_tdata_kept", {16'd0, tdata}, 32'h5555);
    tready = 1'b0;

    // Stall: head word held for 50 cycles.
    n = 0;
    while (tvalid !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL stall_setup: got no expected word want one");
    end else begin
      repeat (50) begin
        @(posedge clk); #1;
        chk("stall50_tvalid", {31'd0, tvalid}, 32'd1);
        chk("stall50_tdata", {16'd0, tdata}, {16'd0, exp_q[0]});
      end
      take_word("stall_take");
    end

    // Reset in the middle of a conversion.
    wait_cs(1'b0, 300, "mid_sync_fall");
    wait_cs(1'b1, 300, "mid_sync_rise");
    drain_all();
    adc_q.push_back(16'hDEAD);
    wait_cs(1'b0, 300, "mid_fall");
    n = 0;
    while (fall_cnt < 8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_falls", fall_cnt, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    aresetn = 1'b0;
    exp_q.delete();
    adc_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_cs", {31'd0, spi_chipselect}, 32'd1);
      chk("mid_rst_sclk", {31'd0, spi_clock}, 32'd1);
      chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
    end
    @(negedge clk);
    aresetn = 1'b1;
    adc_q.push_back(16'hA5C3);
    repeat (100) begin
      @(posedge clk); #1;
    end
    chk("post_rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("post_rst_cs", {31'd0, spi_chipselect}, 32'd1);
    target = n_pops + 1;
    take_word("post_rst_word");
    chk("post_rst_pops", n_pops, target);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic_get_samples.md
Name: mic_get_samples

Overview:
Periodic SPI master that reads 16-bit samples from a microphone ADC (Pmod-MIC style). It buffers the samples in a small FIFO and delivers them on an AXI4-Stream master port. It sits between the off-chip ADC pins and a DMA/stream consumer, and runs entirely in the AXIS clock domain.

Parameters:
CLK_TRIG, 2, half-period of spi_clock in aclk cycles (spi_clock period = 2*CLK_TRIG cycles); must be ≥1.
GRAB_TRIG, 128, conversion start period in aclk cycles; must be ≥ (2*SAMPLE_BITS+2)*CLK_TRIG.
RAM_ADDR_WIDTH, 2, FIFO address width; RAM depth = 2**RAM_ADDR_WIDTH words.
C_M00_AXIS_TDATA_WIDTH, 16, stream width; also the number of SPI bits per conversion (SAMPLE_BITS); must be a multiple of 8.

Ports:
m00_axis_aclk  in  1  sole clock
m00_axis_aresetn  in  1  reset, synchronous, active-low
m00_axis_tvalid  out  1  output word valid
m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  sample, MSB = first bit received
m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  byte strobes, constant all-ones
m00_axis_tready  in  1  consumer ready
spi_clock  out  1  SPI clock, idles high (CPOL=1)
spi_chipselect  out  1  active-low chip select
spi_data  in  1  serial data from ADC; ADC changes it on spi_clock falling edges

Behaviour:
- Reset (aresetn=0 at a rising aclk edge):
  - tvalid=0, tdata=0, spi_clock=1, spi_chipselect=1.
  - FIFO emptied; all counters cleared.
  - An in-flight conversion is aborted and its partial word discarded.
- All outputs are registers. spi_data is sampled directly, with no synchronizer.
- Period counter: free-running 0..GRAB_TRIG-1 after reset release. When it wraps, a conversion starts if state is IDLE; otherwise the start is skipped. The first CS fall occurs GRAB_TRIG cycles after reset release.
- FSM states and transitions:
  - IDLE: CS=1, SCLK=1.
  - SETUP: CS=0, SCLK=1, lasting CLK_TRIG cycles.
  - LOW: SCLK=0 for CLK_TRIG cycles, then go to HIGH.
  - HIGH: SCLK=1 for CLK_TRIG cycles. After the last bit it goes to DONE, otherwise back to LOW.
  - DONE: hold CS=0, SCLK=1 for CLK_TRIG cycles, then CS=1 and return to IDLE.
- Bit capture:
  - On the aclk edge that drives spi_clock 0→1, shift spi_data into the LSB of the shift register (MSB-first).
  - Exactly C_M00_AXIS_TDATA_WIDTH bits per conversion, i.e. exactly 16 falling and 16 rising SCLK edges while CS=0.
- FIFO write: on the edge that drives CS 0→1, the assembled word is written into the RAM if it is not full. If full, the word is dropped (no overwrite) and the drop is not reported.
- Output stage:
  - An output register holds the head word. It loads from the RAM when it is empty or when a handshake occurs, and the RAM is non-empty.
  - A word written at edge c appears with tvalid=1 after edge c+1 if the pipeline was empty.
- Handshake: a transfer occurs at a rising edge with tvalid=1 and tready=1.
  - tdata and tvalid are stable while tvalid=1 and tready=0.
  - After the last word is taken, tvalid=0 and tdata retains the last value.
- Simultaneous FIFO write and read in the same cycle are both honoured.
- Total buffering is 2**RAM_ADDR_WIDTH + 1 words. Order is strictly FIFO.

Decomposition:
- Package mic_get_samples_pkg holds:
  - the SPI FSM state enum (IDLE, SETUP, LOW, HIGH, DONE);
  - localparams for SAMPLE_BITS and the bit-counter width (clog2(SAMPLE_BITS+1)).
- One sub-module: mic_sample_fifo, a synchronous FIFO with RAM array, pointers, count, full/empty flags, and the AXIS output register.
- The top contains the period counter, the SPI FSM and the shift register.

Test Plan:
- Reset held 10 cycles: spi_clock=1, spi_chipselect=1, tvalid=0, tdata=0 throughout. First CS fall occurs 128 cycles after release.
- Conversion timing: CS low spans SETUP + 16 SCLK periods of 4 cycles + DONE. Exactly 16 falling edges occur; SCLK is high at CS fall and at CS rise.
- Ten consecutive conversions: for each, drive words 2..11 MSB-first on spi_clock falling edges and pulse tready until the handshake. Each received tdata equals the driven word, tstrb=2'b11.
- Backpressure: tready=0 over 6 conversions of 0x1111..0x6666. Words 1–5 are retained and word 6 is dropped. Then tready=1 yields 0x1111..0x5555 in order and tvalid falls.
- tready=0 while tvalid=1: tdata is held constant across 50 cycles.
- Reset asserted mid-conversion (after 8 bits): CS and SCLK return high and no word is emitted. The next conversion after release is captured correctly (0xA5C3).
